// File: rtl/color_det_pkg.sv
// Shared types and pixel helpers for the multi-ROI dice colour detector.
package color_det_pkg;

  typedef enum logic [1:0] {
    COLOR_NONE  = 2'b00,
    COLOR_RED   = 2'b01,
    COLOR_GREEN = 2'b10,
    COLOR_BLUE  = 2'b11
  } color_e;

  typedef enum logic [2:0] {
    CLASS_NONE  = 3'd0,
    CLASS_RED   = 3'd1,
    CLASS_GREEN = 3'd2,
    CLASS_BLUE  = 3'd3,
    CLASS_WHITE = 3'd4
  } class_e;

  typedef enum logic [1:0] {
    ACCUM   = 2'd0,
    EVAL    = 2'd1,
    PUBLISH = 2'd2
  } state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  function automatic rgb888_t expand_rgb565(input logic [15:0] p);
    rgb888_t c;
    c.r = {p[15:11], p[15:13]};
    c.g = {p[10:5],  p[10:9]};
    c.b = {p[4:0],   p[4:2]};
    return c;
  endfunction

  function automatic class_e classify_pixel(input rgb888_t c, input logic [7:0] hi,
                                            input logic [7:0] lo, input logic [7:0] wmin);
    if (c.r >= wmin && c.g >= wmin && c.b >= wmin) return CLASS_WHITE;
    if (c.r >= hi && c.g <= lo && c.b <= lo)       return CLASS_RED;
    if (c.g >= hi && c.r <= lo && c.b <= lo)       return CLASS_GREEN;
    if (c.b >= hi && c.r <= lo && c.g <= lo)       return CLASS_BLUE;
    return CLASS_NONE;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == '1) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/roi_color_accum.sv
// One ROI: membership test and four saturating per-class pixel counters.
module roi_color_accum
  import color_det_pkg::*;
#(
  parameter int X_LO = 20,
  parameter int X_HI = 140,
  parameter int Y_LO = 60,
  parameter int Y_HI = 180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_valid,
  input  logic        frame_start,
  input  logic [9:0]  wx,
  input  logic [9:0]  wy,
  input  logic [2:0]  pix_class,
  output logic [15:0] cnt_r,
  output logic [15:0] cnt_g,
  output logic [15:0] cnt_b,
  output logic [15:0] cnt_w
);

  logic in_roi, hit, is_r, is_g, is_b, is_w;

  assign in_roi = int'(wx) >= X_LO && int'(wx) < X_HI && int'(wy) >= Y_LO && int'(wy) < Y_HI;
  assign hit    = pix_valid && in_roi;
  assign is_r   = hit && pix_class == CLASS_RED;
  assign is_g   = hit && pix_class == CLASS_GREEN;
  assign is_b   = hit && pix_class == CLASS_BLUE;
  assign is_w   = hit && pix_class == CLASS_WHITE;

  // The frame-start pixel restarts the counts and is itself counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_r <= '0;
      cnt_g <= '0;
      cnt_b <= '0;
      cnt_w <= '0;
    end else if (frame_start) begin
      cnt_r <= {15'd0, is_r};
      cnt_g <= {15'd0, is_g};
      cnt_b <= {15'd0, is_b};
      cnt_w <= {15'd0, is_w};
    end else begin
      if (is_r) cnt_r <= sat_inc(cnt_r);
      if (is_g) cnt_g <= sat_inc(cnt_g);
      if (is_b) cnt_b <= sat_inc(cnt_b);
      if (is_w) cnt_w <= sat_inc(cnt_w);
    end
  end

endmodule

// File: rtl/multi_roi_color_detector.sv
// NUM_ROI parallel dice colour classifiers with multi-frame stability filtering.
// Optional ROI overlay video output when CD_ROI_OVERLAY_EN is defined.
module multi_roi_color_detector
  import color_det_pkg::*;
#(
  parameter int NUM_ROI       = 2,
  parameter int FB_X0         = 0,
  parameter int FB_Y0         = 240,
  parameter int FB_W          = 320,
  parameter int FB_H          = 240,
  parameter int ROI_X0        = 20,
  parameter int ROI_Y0        = 60,
  parameter int ROI_W         = 120,
  parameter int ROI_H         = 120,
  parameter int ROI_PITCH     = 160,
  parameter int R_HI          = 140,
  parameter int R_LO          = 130,
  parameter int W_MIN         = 160,
  parameter int MIN_PIXELS    = 200,
  parameter int WHITE_PIXELS  = 5000,
  parameter int STABLE_FRAMES = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    DE,
  input  logic [9:0]              x_pixel,
  input  logic [9:0]              y_pixel,
  input  logic [15:0]             pixel_rgb_data,
  output logic [2*NUM_ROI-1:0]    stable_color,
  output logic [NUM_ROI-1:0]      result_ready,
  output logic [NUM_ROI-1:0]      white_state,
  output logic                    all_white,
  output logic [16*NUM_ROI-1:0]   confidence,
  output logic                    frame_done
`ifdef CD_ROI_OVERLAY_EN
  ,
  output logic                    overlay_valid,
  output logic [15:0]             overlay_rgb565
`endif
);

  localparam logic [1:0] LAST_IDX = 2'(NUM_ROI - 1);
  localparam logic [7:0] SF       = 8'(STABLE_FRAMES);

  logic       in_win, pix_valid, frame_start, last_pix;
  logic [9:0] wx, wy;
  logic [2:0] pix_class;

  assign in_win = int'(x_pixel) >= FB_X0 && int'(x_pixel) < FB_X0 + FB_W &&
                  int'(y_pixel) >= FB_Y0 && int'(y_pixel) < FB_Y0 + FB_H;
  assign wx          = x_pixel - 10'(FB_X0);
  assign wy          = y_pixel - 10'(FB_Y0);
  assign pix_valid   = DE && in_win;
  assign frame_start = pix_valid && wx == '0 && wy == '0;
  assign last_pix    = pix_valid && wx == 10'(FB_W - 1) && wy == 10'(FB_H - 1);
  assign pix_class   = classify_pixel(expand_rgb565(pixel_rgb_data),
                                      8'(R_HI), 8'(R_LO), 8'(W_MIN));

  logic [15:0] cnt_r [NUM_ROI];
  logic [15:0] cnt_g [NUM_ROI];
  logic [15:0] cnt_b [NUM_ROI];
  logic [15:0] cnt_w [NUM_ROI];

  for (genvar g = 0; g < NUM_ROI; g++) begin : g_roi
    roi_color_accum #(
      .X_LO(ROI_X0 + g * ROI_PITCH),
      .X_HI(ROI_X0 + g * ROI_PITCH + ROI_W),
      .Y_LO(ROI_Y0),
      .Y_HI(ROI_Y0 + ROI_H)
    ) u_accum (
      .clk        (clk),
      .reset      (reset),
      .pix_valid  (pix_valid),
      .frame_start(frame_start),
      .wx         (wx),
      .wy         (wy),
      .pix_class  (pix_class),
      .cnt_r      (cnt_r[g]),
      .cnt_g      (cnt_g[g]),
      .cnt_b      (cnt_b[g]),
      .cnt_w      (cnt_w[g])
    );
  end

  state_e     state_q, state_d;
  logic [1:0] roi_idx, idx_d;
  logic       armed, go_eval, do_eval, do_publish;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ACCUM;
      roi_idx <= '0;
    end else begin
      state_q <= state_d;
      roi_idx <= idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = roi_idx;
    go_eval    = 1'b0;
    do_eval    = 1'b0;
    do_publish = 1'b0;
    case (state_q)
      ACCUM: if (last_pix && (armed || frame_start)) begin
        state_d = EVAL;
        idx_d   = '0;
        go_eval = 1'b1;
      end
      EVAL: begin
        do_eval = 1'b1;
        if (roi_idx == LAST_IDX) state_d = PUBLISH;
        else                     idx_d   = roi_idx + 2'd1;
      end
      PUBLISH: begin
        do_publish = 1'b1;
        state_d    = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  logic [15:0] sh_r [NUM_ROI];
  logic [15:0] sh_g [NUM_ROI];
  logic [15:0] sh_b [NUM_ROI];
  logic [15:0] sh_w [NUM_ROI];
  logic [2:0]  last_cls [NUM_ROI];
  logic [7:0]  run [NUM_ROI];
  logic [NUM_ROI-1:0] pend;

  logic [15:0] ev_r, ev_g, ev_b, ev_w, best, fconf;
  logic [2:0]  bcls, fclass, sel_last;
  logic [7:0]  sel_run, run_next;
  logic [1:0]  sel_color;
  logic        sel_white, upd, pulse;

  always_comb begin
    ev_r = '0; ev_g = '0; ev_b = '0; ev_w = '0;
    sel_last = CLASS_NONE; sel_run = '0; sel_color = COLOR_NONE; sel_white = 1'b0;
    for (int unsigned i = 0; i < NUM_ROI; i++) begin
      if (roi_idx == 2'(i)) begin
        // ROI 0 is judged on the edge that loads the shadows, so it reads the live counts.
        ev_r      = (i == 0) ? cnt_r[i] : sh_r[i];
        ev_g      = (i == 0) ? cnt_g[i] : sh_g[i];
        ev_b      = (i == 0) ? cnt_b[i] : sh_b[i];
        ev_w      = (i == 0) ? cnt_w[i] : sh_w[i];
        sel_last  = last_cls[i];
        sel_run   = run[i];
        sel_color = stable_color[2*i +: 2];
        sel_white = white_state[i];
      end
    end
    best = ev_r;
    bcls = CLASS_RED;
    if (!(ev_r >= ev_g && ev_r >= ev_b)) begin
      if (ev_g >= ev_b) begin best = ev_g; bcls = CLASS_GREEN; end
      else              begin best = ev_b; bcls = CLASS_BLUE;  end
    end
    fclass = CLASS_NONE;
    fconf  = '0;
    if (ev_w >= 16'(WHITE_PIXELS)) begin
      fclass = CLASS_WHITE;
      fconf  = ev_w;
    end else if (best >= 16'(MIN_PIXELS)) begin
      fclass = bcls;
      fconf  = best;
    end
    run_next = (fclass == sel_last) ? ((sel_run >= SF) ? sel_run : sel_run + 8'd1) : 8'd1;
    upd      = run_next == SF;
    pulse    = upd && fclass != CLASS_NONE && fclass != CLASS_WHITE &&
               (sel_color != fclass[1:0] || sel_white);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      armed        <= 1'b0;
      pend         <= '0;
      frame_done   <= 1'b0;
      result_ready <= '0;
      stable_color <= '0;
      white_state  <= '0;
      confidence   <= '0;
      for (int unsigned i = 0; i < NUM_ROI; i++) begin
        sh_r[i] <= '0; sh_g[i] <= '0; sh_b[i] <= '0; sh_w[i] <= '0;
        last_cls[i] <= CLASS_NONE;
        run[i]      <= '0;
      end
    end else begin
      if (go_eval)          armed <= 1'b0;
      else if (frame_start) armed <= 1'b1;
      frame_done   <= do_publish;
      result_ready <= do_publish ? pend : '0;
      if (do_publish) pend <= '0;
      for (int unsigned i = 0; i < NUM_ROI; i++) begin
        if (do_eval && roi_idx == 2'd0) begin
          sh_r[i] <= cnt_r[i]; sh_g[i] <= cnt_g[i]; sh_b[i] <= cnt_b[i]; sh_w[i] <= cnt_w[i];
        end
        if (do_eval && roi_idx == 2'(i)) begin
          last_cls[i]            <= fclass;
          run[i]                 <= run_next;
          confidence[16*i +: 16] <= fconf;
          if (pulse) pend[i] <= 1'b1;
          if (upd) begin
            case (fclass)
              CLASS_RED, CLASS_GREEN, CLASS_BLUE: begin
                stable_color[2*i +: 2] <= fclass[1:0];
                white_state[i]         <= 1'b0;
              end
              CLASS_WHITE: begin
                stable_color[2*i +: 2] <= COLOR_NONE;
                white_state[i]         <= 1'b1;
              end
              default: ;
            endcase
          end
        end
      end
    end
  end

  assign all_white = &white_state;

`ifdef CD_ROI_OVERLAY_EN
  function automatic logic in_rect(input logic [9:0] px, input logic [9:0] py,
                                   input int x0, input int x1, input int y0, input int y1);
    return int'(px) >= x0 && int'(px) < x1 && int'(py) >= y0 && int'(py) < y1;
  endfunction

  logic [15:0] ov_pix;

  always_comb begin
    ov_pix = pixel_rgb_data;
    for (int unsigned i = 0; i < NUM_ROI; i++) begin
      if (pix_valid && in_rect(wx, wy, ROI_X0 + int'(i) * ROI_PITCH,
                               ROI_X0 + int'(i) * ROI_PITCH + ROI_W, ROI_Y0, ROI_Y0 + ROI_H)) begin
        if (!in_rect(wx, wy, ROI_X0 + int'(i) * ROI_PITCH + 1,
                     ROI_X0 + int'(i) * ROI_PITCH + ROI_W - 1, ROI_Y0 + 1, ROI_Y0 + ROI_H - 1)) begin
          ov_pix = 16'hFFE0;
        end else if (!in_rect(wx, wy, ROI_X0 + int'(i) * ROI_PITCH + 3,
                              ROI_X0 + int'(i) * ROI_PITCH + ROI_W - 3,
                              ROI_Y0 + 3, ROI_Y0 + ROI_H - 3)) begin
          case (stable_color[2*i +: 2])
            COLOR_RED:   ov_pix = 16'hF800;
            COLOR_GREEN: ov_pix = 16'h07E0;
            COLOR_BLUE:  ov_pix = 16'h001F;
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overlay_valid  <= 1'b0;
      overlay_rgb565 <= '0;
    end else begin
      overlay_valid  <= DE;
      overlay_rgb565 <= ov_pix;
    end
  end
`endif

endmodule
